// File: rtl/l2_amo_initiator_if.sv
// Core-side and L2-side AMO handshake bundle for l2_amo_initiator.
// master: the initiator. slave: the core/L1.5 and the L2 around it.
interface l2_amo_initiator_if #(
  parameter int OP_W   = 4,
  parameter int ADDR_W = 40,
  parameter int SIZE_W = 3,
  parameter int LINE_W = 128
);
  logic              core_req_valid;
  logic              core_req_ready;
  logic [OP_W-1:0]   core_req_op;
  logic [ADDR_W-1:0] core_req_addr;
  logic [SIZE_W-1:0] core_req_size;
  logic [63:0]       core_req_data;
  logic              core_req_sext;
  logic              core_resp_valid;
  logic              core_resp_ready;
  logic [63:0]       core_resp_data;
  logic [1:0]        core_resp_err;
  logic              l2_req_valid;
  logic              l2_req_ready;
  logic [OP_W-1:0]   l2_req_op;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [SIZE_W-1:0] l2_req_size;
  logic [LINE_W-1:0] l2_req_data;
  logic              l2_resp_valid;
  logic              l2_resp_ready;
  logic [LINE_W-1:0] l2_resp_data;
  logic              busy;

  modport master (
    input  core_req_valid, core_req_op, core_req_addr,
    input  core_req_size, core_req_data, core_req_sext,
    output core_req_ready,
    output core_resp_valid, core_resp_data, core_resp_err,
    input  core_resp_ready,
    output l2_req_valid, l2_req_op, l2_req_addr,
    output l2_req_size, l2_req_data,
    input  l2_req_ready,
    input  l2_resp_valid, l2_resp_data,
    output l2_resp_ready,
    output busy
  );

  modport slave (
    output core_req_valid, core_req_op, core_req_addr,
    output core_req_size, core_req_data, core_req_sext,
    input  core_req_ready,
    input  core_resp_valid, core_resp_data, core_resp_err,
    output core_resp_ready,
    input  l2_req_valid, l2_req_op, l2_req_addr,
    input  l2_req_size, l2_req_data,
    output l2_req_ready,
    output l2_resp_valid, l2_resp_data,
    input  l2_resp_ready,
    input  busy
  );
endinterface

// File: rtl/l2_amo_initiator.sv
// Requester side of the L2 atomic ALU: one AMO in flight, operand laid
// into the L2 line, old value extracted/extended back to the core.
// Ports: clk, rst (async active-high), bus (l2_amo_initiator_if.master):
//  core_req_* in / core_resp_* out, l2_req_* out / l2_resp_* in, busy.
module l2_amo_initiator #(
  parameter int SWAP_ENDIANESS = 1,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OP_W           = 4,
  parameter int ADDR_W         = 40,
  parameter int SIZE_W         = 3,
  parameter int LINE_W         = 128
) (
  input logic clk,
  input logic rst,
  l2_amo_initiator_if.master bus
);
  localparam int DIDX_W = $clog2(LINE_W / 64);
  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT, RESP, DRAIN
  } state_e;

  // Byte count of a size code; 0 marks an unsupported size.
  function automatic logic [3:0] size_bytes(
    input logic [SIZE_W-1:0] s);
    unique case (s)
      SIZE_W'(1): size_bytes = 4'd1;
      SIZE_W'(2): size_bytes = 4'd2;
      SIZE_W'(3): size_bytes = 4'd4;
      SIZE_W'(4): size_bytes = 4'd8;
      default:    size_bytes = 4'd0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              sext_q, sext_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              drain_q, drain_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [3:0]          nb_in, nb_q;
  logic [2:0]          a_in, a_q;
  logic [DIDX_W-1:0]   d_in, d_q;
  logic                req_ok;
  logic [LINE_W-1:0]   place;
  logic [63:0]         ext;
  logic [2:0]          lane_p, lane_x;
  logic                sgn;

  assign nb_in = size_bytes(bus.core_req_size);
  assign a_in  = bus.core_req_addr[2:0];
  assign d_in  = bus.core_req_addr[3 +: DIDX_W];
  assign nb_q  = size_bytes(size_q);
  assign a_q   = addr_q[2:0];
  assign d_q   = addr_q[3 +: DIDX_W];

  assign req_ok = (nb_in != 4'd0) &&
    ((({1'b0, a_in}) & (nb_in - 4'd1)) == 4'd0);

  // Operand byte i lands on byte address a+i of dword d.
  always_comb begin
    place  = '0;
    lane_p = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nb_in) begin
        lane_p = a_in + 3'(i);
        if (SWAP_ENDIANESS != 0) lane_p = ~lane_p;
        place[{d_in, lane_p, 3'b000} +: 8] =
          bus.core_req_data[i*8 +: 8];
      end
    end
  end

  // Exact inverse of the placement, then sign/zero fill above size.
  always_comb begin
    ext    = '0;
    lane_x = '0;
    sgn    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nb_q) begin
        lane_x = a_q + 3'(i);
        if (SWAP_ENDIANESS != 0) lane_x = ~lane_x;
        ext[i*8 +: 8] =
          bus.l2_resp_data[{d_q, lane_x, 3'b000} +: 8];
      end
    end
    unique case (nb_q)
      4'd1:    sgn = ext[7];
      4'd2:    sgn = ext[15];
      4'd4:    sgn = ext[31];
      default: sgn = 1'b0;
    endcase
    if (sext_q && sgn) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) >= nb_q) ext[i*8 +: 8] = 8'hFF;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sext_d  = sext_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.core_req_valid) begin
          op_d   = bus.core_req_op;
          addr_d = bus.core_req_addr;
          size_d = bus.core_req_size;
          sext_d = bus.core_req_sext;
          if (req_ok) begin
            line_d  = place;
            state_d = SEND;
          end else begin
            rdata_d = '0;
            err_d   = 2'b01;
            state_d = RESP;
          end
        end
      end
      SEND: begin
        if (bus.l2_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.l2_resp_valid) begin
          rdata_d = ext;
          err_d   = 2'b00;
          state_d = RESP;
        end else if (TIMEOUT_CYCLES != 0 &&
                     cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 2'b10;
          drain_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (drain_q && bus.l2_resp_valid) drain_d = 1'b0;
        if (bus.core_resp_ready)
          state_d = drain_d ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (bus.l2_resp_valid) drain_d = 1'b0;
        if (!drain_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      line_q  <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      drain_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.core_req_ready  = (state_q == IDLE);
  assign bus.core_resp_valid = (state_q == RESP);
  assign bus.core_resp_data  = rdata_q;
  assign bus.core_resp_err   = err_q;
  assign bus.l2_req_valid    = (state_q == SEND);
  assign bus.l2_req_op       = op_q;
  assign bus.l2_req_addr     = addr_q;
  assign bus.l2_req_size     = size_q;
  assign bus.l2_req_data     = line_q;
  assign bus.l2_resp_ready   = (state_q == WAIT) || drain_q;
  assign bus.busy            = (state_q != IDLE);
endmodule
